// File: rtl/muldiv.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// Radix-2 shift-add multiply and restoring divide, one bit per clock.
module muldiv #(
    parameter int WORD_SIZE = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [2:0]           op_i,
    input  logic [WORD_SIZE-1:0] rs_data_i,
    input  logic [WORD_SIZE-1:0] rt_data_i,
    input  logic                 cancel_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [WORD_SIZE-1:0] hi_o,
    output logic [WORD_SIZE-1:0] lo_o
);
    localparam int W  = WORD_SIZE;
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2*W-1:0]  acc_q, acc_d;
    logic [W-1:0]    opnd_q, opnd_d;
    logic [W-1:0]    a_orig_q, a_orig_d;
    logic            is_div_q, is_div_d;
    logic            neg_q, neg_d;
    logic            rem_neg_q, rem_neg_d;
    logic [W-1:0]    hi_q, hi_d;
    logic [W-1:0]    lo_q, lo_d;
    logic            done_q, done_d;

    // Signed ops work on magnitudes; the most negative value maps to itself as unsigned.
    logic            a_neg, b_neg;
    logic [W-1:0]    a_mag, b_mag;
    assign a_neg = ~op_i[0] & rs_data_i[W-1];
    assign b_neg = ~op_i[0] & rt_data_i[W-1];
    assign a_mag = a_neg ? -rs_data_i : rs_data_i;
    assign b_mag = b_neg ? -rt_data_i : rt_data_i;

    // Multiply: acc = {partial product, remaining multiplier bits}.
    logic [W:0]      mul_sum;
    logic [2*W-1:0]  mul_next;
    assign mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : {(W+1){1'b0}});
    assign mul_next = {mul_sum, acc_q[W-1:1]};

    // Divide: acc = {partial remainder, dividend bits shifting into quotient}.
    logic [W:0]      div_shift;
    logic [W+1:0]    div_trial;
    logic            div_ge;
    logic [W-1:0]    div_rem;
    logic [2*W-1:0]  div_next;
    assign div_shift = {acc_q[2*W-1:W], acc_q[W-1]};
    assign div_trial = {1'b0, div_shift} - {2'b00, opnd_q};
    assign div_ge    = ~div_trial[W+1];
    assign div_rem   = div_ge ? div_trial[W-1:0] : div_shift[W-1:0];
    assign div_next  = {div_rem, acc_q[W-2:0], div_ge};

    logic [2*W-1:0]  prod_fix;
    logic [W-1:0]    quot_fix, rem_fix;
    assign prod_fix = neg_q ? -acc_q : acc_q;
    assign quot_fix = neg_q ? -acc_q[W-1:0] : acc_q[W-1:0];
    assign rem_fix  = rem_neg_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        a_orig_d  = a_orig_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i && !cancel_i) begin
                    case (op_i)
                        3'b100: hi_d = rs_data_i;
                        3'b101: lo_d = rs_data_i;
                        3'b000, 3'b001, 3'b010, 3'b011: begin
                            is_div_d  = op_i[1];
                            neg_d     = a_neg ^ b_neg;
                            rem_neg_d = a_neg;
                            a_orig_d  = rs_data_i;
                            cnt_d     = '0;
                            state_d   = CALC;
                            if (op_i[1]) begin
                                acc_d  = {{W{1'b0}}, a_mag};
                                opnd_d = b_mag;
                            end else begin
                                acc_d  = {{W{1'b0}}, b_mag};
                                opnd_d = a_mag;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            CALC: begin
                if (cancel_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    acc_d = is_div_q ? div_next : mul_next;
                    if (cnt_q == CW'(W-1)) begin
                        cnt_d   = '0;
                        state_d = FIX;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            FIX: begin
                state_d = IDLE;
                if (!cancel_i) begin
                    done_d = 1'b1;
                    if (!is_div_q) begin
                        {hi_d, lo_d} = prod_fix;
                    end else if (opnd_q == '0) begin
                        lo_d = '1;
                        hi_d = a_orig_q;
                    end else begin
                        lo_d = quot_fix;
                        hi_d = rem_fix;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            a_orig_q  <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            a_orig_q  <= a_orig_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign busy_o = (state_q == CALC) || (state_q == FIX);
    assign done_o = done_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;
endmodule

// File: tb/tb_muldiv.sv
// Self-checking bench for muldiv: vector table plus scoreboard queue of expected {HI,LO}.
module tb_muldiv;
    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        start_i;
    logic [2:0]  op_i;
    logic [31:0] rs_data_i, rt_data_i;
    logic        cancel_i;
    logic        busy_o, done_o;
    logic [31:0] hi_o, lo_o;

    muldiv #(.WORD_SIZE(32)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .op_i(op_i),
        .rs_data_i(rs_data_i), .rt_data_i(rt_data_i), .cancel_i(cancel_i),
        .busy_o(busy_o), .done_o(done_o), .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b, ehi, elo;
    } vec_t;

    vec_t        vecs[12];
    logic [63:0] exp_q[$];
    int          total = 0;
    int          bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        start_i = 1'b1;
        op_i = op;
        rs_data_i = a;
        rt_data_i = b;
        tick();
        start_i = 1'b0;
    endtask

    // Returns while done_o is high (one time-step after the completing edge).
    task automatic wait_done(input string name, input int pre);
        int cyc = 0;
        int busy_cyc = pre;
        logic [63:0] req;
        while (!done_o && cyc < 60) begin
            if (busy_o) busy_cyc++;
            tick();
            cyc++;
        end
        if (!done_o) begin
            chk({name, "_timeout"}, 64'(done_o), 64'd1);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            return;
        end
        if (exp_q.size() == 0) begin
            chk({name, "_sb_empty"}, 64'd0, 64'd1);
            return;
        end
        req = exp_q.pop_front();
        chk(name, {hi_o, lo_o}, req);
        chk({name, "_latency"}, 64'(cyc + pre), 64'd33);
        chk({name, "_busy_cycles"}, 64'(busy_cyc), 64'd33);
        $display("txn %s op=%0d a=%h b=%h hi=%h lo=%h", name, op_i, rs_data_i, rt_data_i, hi_o, lo_o);
    endtask

    initial begin
        int seen_done;
        vecs[0]  = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1]  = '{3'b000, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[2]  = '{3'b010, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{3'b011, 32'd100,      32'h00000000, 32'd100,      32'hFFFFFFFF};
        vecs[4]  = '{3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[5]  = '{3'b011, 32'd9,        32'd3,        32'd0,        32'd3};
        vecs[6]  = '{3'b000, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[7]  = '{3'b010, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
        vecs[8]  = '{3'b010, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF};
        vecs[9]  = '{3'b000, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001};
        vecs[10] = '{3'b011, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};
        vecs[11] = '{3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};

        rst_ni = 1'b0; start_i = 1'b0; op_i = 3'b000; cancel_i = 1'b0;
        rs_data_i = '0; rt_data_i = '0;
        repeat (3) tick();
        chk("reset_busy", 64'(busy_o), 64'd0);
        chk("reset_done", 64'(done_o), 64'd0);
        chk("reset_hilo", {hi_o, lo_o}, 64'd0);
        rst_ni = 1'b1;
        tick();
        chk("post_reset_hilo", {hi_o, lo_o}, 64'd0);

        // MTHI then MTLO on consecutive edges
        issue(3'b100, 32'h1234, 32'h0);
        chk("mthi_done", 64'(done_o), 64'd0);
        issue(3'b101, 32'h5678, 32'h0);
        chk("mt_hilo", {hi_o, lo_o}, {32'h1234, 32'h5678});
        chk("mt_done", 64'(done_o), 64'd0);
        chk("mt_busy", 64'(busy_o), 64'd0);

        issue(3'b110, 32'hDEAD, 32'hBEEF);
        chk("reserved_busy", 64'(busy_o), 64'd0);
        chk("reserved_hilo", {hi_o, lo_o}, {32'h1234, 32'h5678});

        for (int i = 0; i < 12; i++) begin
            exp_q.push_back({vecs[i].ehi, vecs[i].elo});
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done($sformatf("vec%0d", i), 0);
            tick();
            chk($sformatf("vec%0d_pulse", i), 64'(done_o), 64'd0);
            chk($sformatf("vec%0d_idle", i), 64'(busy_o), 64'd0);
        end

        // Cancel mid-divide leaves preloaded HI/LO intact
        issue(3'b100, 32'hAA, 32'h0);
        issue(3'b101, 32'hBB, 32'h0);
        issue(3'b011, 32'd9, 32'd3);
        repeat (20) tick();
        chk("cancel_pre_busy", 64'(busy_o), 64'd1);
        cancel_i = 1'b1;
        tick();
        cancel_i = 1'b0;
        chk("cancel_busy", 64'(busy_o), 64'd0);
        seen_done = 0;
        for (int i = 0; i < 40; i++) begin
            if (done_o) seen_done = 1;
            tick();
        end
        chk("cancel_no_done", 64'(seen_done), 64'd0);
        chk("cancel_hilo", {hi_o, lo_o}, {32'hAA, 32'hBB});

        // cancel in IDLE drops a simultaneous start
        cancel_i = 1'b1;
        issue(3'b101, 32'h77, 32'h0);
        cancel_i = 1'b0;
        chk("cancel_idle_lo", 64'(lo_o), 64'hBB);

        // MTLO while busy is ignored; then back-to-back start on the done cycle
        exp_q.push_back({32'd0, 32'd35});
        issue(3'b001, 32'd5, 32'd7);
        issue(3'b101, 32'h999, 32'h0);
        chk("busy_mtlo_lo", 64'(lo_o), 64'hBB);
        wait_done("mul5x7", 1);
        exp_q.push_back({32'd0, 32'd6});
        issue(3'b001, 32'd2, 32'd3);
        chk("b2b_pulse", 64'(done_o), 64'd0);
        chk("b2b_busy", 64'(busy_o), 64'd1);
        wait_done("b2b_mul2x3", 0);

        // Asynchronous reset mid-calculation
        issue(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (10) tick();
        rst_ni = 1'b0;
        #1;
        chk("async_rst_busy", 64'(busy_o), 64'd0);
        chk("async_rst_hilo", {hi_o, lo_o}, 64'd0);
        tick();
        rst_ni = 1'b1;
        tick();
        chk("async_rst_done", 64'(done_o), 64'd0);
        chk("sb_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
